muldiv_seq: RTL and testbench

//  Iterative radix-2 multiply/divide sequencer for RISC-V RV32M unsigned ops (MUL, MULHU, DIVU, REMU).

---
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_muldiv_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide sequencer for the RV32M unsigned ops
// MUL, MULHU, DIVU and REMU. It takes one operation at a time, holds the
// EX stage through stall_o while it iterates, and presents the result for
// one DONE cycle.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     b_q, b_d;
    // Product register for multiply; its low half doubles as the quotient
    // shift register during divide.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic [XLEN:0]       upper_sum;
    logic [2*XLEN-1:0]   prod_next;
    logic [XLEN:0]       rem_shift;
    logic                rem_ge;
    logic [XLEN-1:0]     rem_next;
    logic [XLEN-1:0]     quo_next;

    // One iteration step of both datapaths, computed from the current registers.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
        prod_next = {upper_sum, acc_q[XLEN-1:1]};
        rem_shift = {rem_q, acc_q[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_next  = rem_ge ? (rem_shift[XLEN-1:0] - b_q) : rem_shift[XLEN-1:0];
        quo_next  = {acc_q[XLEN-2:0], rem_ge};
    end

    // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d = op_i;
                    b_d  = b_i;
                    if (op_i[1] && (b_i == {XLEN{1'b0}})) begin
                        // Divide by zero returns the architecturally defined
                        // values without iterating.
                        state_d  = ST_DONE;
                        result_d = (op_i == OP_REMU) ? a_i : {XLEN{1'b1}};
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(XLEN);
                        acc_d   = {{XLEN{1'b0}}, a_i};
                        rem_d   = {XLEN{1'b0}};
                    end
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[1]) begin
                        acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
                        rem_d = rem_next;
                    end else begin
                        acc_d = prod_next;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        case (op_q)
                            OP_MUL:   result_d = prod_next[XLEN-1:0];
                            OP_MULHU: result_d = prod_next[2*XLEN-1:XLEN];
                            OP_DIVU:  result_d = quo_next;
                            default:  result_d = rem_next;
                        endcase
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // The stall must cover the accepting IDLE cycle, so it looks at start_i directly.
    always_comb begin
        busy_o   = (state_q == ST_RUN) || (state_q == ST_DONE);
        done_o   = (state_q == ST_DONE);
        stall_o  = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_RUN);
        result_o = result_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks;
    int failures;

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from IDLE and wait (bounded) for done_o. Returns the result,
    // the number of edges from acceptance to DONE, and the stall cycles seen.
    // Leaves the bench 1 time unit after the edge that returns the DUT to IDLE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat     = 0;
        stalls  = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            if (stall_o === 1'b1) stalls++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result_o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        #12;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs busy=%b done=%b stall=%b result=%h expected 0 0 0 00000000",
                     busy_o, done_o, stall_o, result_o);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int lat, stalls;
        run_op(2'b00, 32'd7, 32'd6, res, lat, stalls);
        checks++;
        if (res !== 32'd42) begin
            failures++;
            $display("[TB] FAIL mul_7x6 got %0d expected 42", res);
        end
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("[TB] FAIL mul_latency got %0d edges expected 32", lat);
        end
        checks++;
        if (stalls !== 32) begin
            failures++;
            $display("[TB] FAIL mul_stall_cycles got %0d expected 32", stalls);
        end
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'd42) begin
            failures++;
            $display("[TB] FAIL mul_after_done done=%b busy=%b result=%0d expected 0 0 42",
                     done_o, busy_o, result_o);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, stalls);
        checks++;
        if (res !== 32'hFFFF_FFFE) begin
            failures++;
            $display("[TB] FAIL mulhu_max got %h expected fffffffe", res);
        end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, stalls);
        checks++;
        if (res !== 32'h0000_0001) begin
            failures++;
            $display("[TB] FAIL mul_max got %h expected 00000001", res);
        end
        run_op(2'b01, 32'h8000_0000, 32'd6, res, lat, stalls);
        checks++;
        if (res !== 32'd3) begin
            failures++;
            $display("[TB] FAIL mulhu_shift got %h expected 00000003", res);
        end
    endtask

    task automatic test_divide();
        logic [31:0] res;
        int lat, stalls;
        run_op(2'b10, 32'd100, 32'd7, res, lat, stalls);
        checks++;
        if (res !== 32'd14 || lat !== 32) begin
            failures++;
            $display("[TB] FAIL divu_100_7 got %0d lat %0d expected 14 lat 32", res, lat);
        end
        run_op(2'b11, 32'd100, 32'd7, res, lat, stalls);
        checks++;
        if (res !== 32'd2) begin
            failures++;
            $display("[TB] FAIL remu_100_7 got %0d expected 2", res);
        end
        run_op(2'b10, 32'd5, 32'd9, res, lat, stalls);
        checks++;
        if (res !== 32'd0) begin
            failures++;
            $display("[TB] FAIL divu_5_9 got %0d expected 0", res);
        end
        run_op(2'b11, 32'd5, 32'd9, res, lat, stalls);
        checks++;
        if (res !== 32'd5) begin
            failures++;
            $display("[TB] FAIL remu_5_9 got %0d expected 5", res);
        end
        run_op(2'b10, 32'hFFFF_FFFF, 32'd16, res, lat, stalls);
        checks++;
        if (res !== 32'h0FFF_FFFF) begin
            failures++;
            $display("[TB] FAIL divu_max_16 got %h expected 0fffffff", res);
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] res;
        int lat, stalls;
        run_op(2'b10, 32'd123, 32'd0, res, lat, stalls);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 0) begin
            failures++;
            $display("[TB] FAIL divu_by_zero got %h lat %0d expected ffffffff lat 0", res, lat);
        end
        run_op(2'b11, 32'd123, 32'd0, res, lat, stalls);
        checks++;
        if (res !== 32'd123 || lat !== 0) begin
            failures++;
            $display("[TB] FAIL remu_by_zero got %0d lat %0d expected 123 lat 0", res, lat);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, stalls, dones;
        // Flush together with start in IDLE drops the request.
        op_i    = 2'b00;
        a_i     = 32'd9;
        b_i     = 32'd9;
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle_stall got %b expected 0", stall_o);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle_busy got %b expected 0", busy_o);
        end
        // Flush in RUN cycle 10 aborts without a done pulse.
        op_i    = 2'b00;
        a_i     = 32'd5;
        b_i     = 32'd5;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_run_idle busy=%b stall=%b expected 0 0", busy_o, stall_o);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dones !== 0 || result_o !== 32'd123) begin
            failures++;
            $display("[TB] FAIL flush_run_no_done dones=%0d result=%0d expected 0 123", dones, result_o);
        end
        run_op(2'b00, 32'd3, 32'd4, res, lat, stalls);
        checks++;
        if (res !== 32'd12) begin
            failures++;
            $display("[TB] FAIL mul_after_flush got %0d expected 12", res);
        end
        // Flush in DONE still shows the pulse and the result.
        op_i    = 2'b10;
        a_i     = 32'd50;
        b_i     = 32'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL flush_done_pulse done=%b result=%h expected 1 ffffffff", done_o, result_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || result_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL flush_done_idle busy=%b result=%h expected 0 ffffffff", busy_o, result_o);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        op_i    = 2'b00;
        a_i     = 32'd7;
        b_i     = 32'd6;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                start_i = 1'b1;
                op_i    = 2'b10;
                a_i     = 32'd1000;
                b_i     = 32'd3;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (result_o !== 32'd42 || lat !== 32) begin
            failures++;
            $display("[TB] FAIL busy_ignore result=%0d lat=%0d expected 42 lat 32", result_o, lat);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_stall got %b expected 0", stall_o);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int lat, stalls;
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, r1, lat, stalls);
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, r2, lat, stalls);
        checks++;
        if (r1 !== 32'h0 || r2 !== 32'h1) begin
            failures++;
            $display("[TB] FAIL back_to_back got %h %h expected 00000000 00000001", r1, r2);
        end
    endtask

    task automatic test_async_reset();
        op_i    = 2'b00;
        a_i     = 32'd11;
        b_i     = 32'd11;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset busy=%b done=%b stall=%b result=%h expected 0 0 0 00000000",
                     busy_o, done_o, stall_o, result_o);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_divide();
        test_div_by_zero();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
